// File: rtl/h2f_vram_writer.sv
// h2f_vram_writer
//   Buffers HPS-to-FPGA VRAM writes in a small FIFO and hands them, one at a
//   time, to the VRAM write selector. Addresses, data and byte enables pass
//   through untouched; region decoding is the write selector's job.
//
// Parameters
//   DEPTH            number of buffered entries (power of two, 2..16)
//
// Ports
//   clk              single clock for all logic
//   reset            asynchronous, active-high reset
//   avs_address      13-bit 64-bit-word address from the HPS bus
//   avs_write        bus write request
//   avs_writedata    64-bit write data
//   avs_byteenable   byte lane enables; all-zero writes are dropped
//   avs_waitrequest  stall to the bus, high while the FIFO is full
//   vram_wr_grant    write selector accepts the presented entry this cycle
//   h2f_vram_wraddr  head entry address (zero when idle)
//   h2f_vram_wren    head entry valid
//   h2f_vram_wrdata  head entry data (zero when idle)
//   h2f_vram_byteena head entry byte enables (zero when idle)
//   fifo_count       current occupancy, 0..DEPTH
//   wr_done_count    wrapping count of entries retired to the write selector

module h2f_vram_writer #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [12:0]                avs_address,
    input  logic                       avs_write,
    input  logic [63:0]                avs_writedata,
    input  logic [7:0]                 avs_byteenable,
    output logic                       avs_waitrequest,
    input  logic                       vram_wr_grant,
    output logic [12:0]                h2f_vram_wraddr,
    output logic                       h2f_vram_wren,
    output logic [63:0]                h2f_vram_wrdata,
    output logic [7:0]                 h2f_vram_byteena,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [15:0]                wr_done_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 13 + 64 + 8;

    logic [EW-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic [15:0]   done_q,   done_d;

    logic          push;
    logic          pop;
    logic [EW-1:0] head;

    // Stall depends only on registered occupancy, never on this cycle's
    // request or grant.
    assign avs_waitrequest = (count_q == CW'(DEPTH));
    assign h2f_vram_wren   = (count_q != '0);

    always_comb begin
        push     = avs_write && !avs_waitrequest && (avs_byteenable != '0);
        pop      = h2f_vram_wren && vram_wr_grant;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        done_d   = done_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            done_d   = done_q + 16'd1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            done_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            done_q   <= done_d;
        end
    end

    // Entry storage needs no reset: contents are only visible through the
    // pointers, which reset clears.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {avs_address, avs_writedata, avs_byteenable};
        end
    end

    // The head is shown only while valid so idle outputs read as zero.
    always_comb begin
        head = h2f_vram_wren ? mem_q[rd_ptr_q] : '0;
    end

    assign h2f_vram_wraddr  = head[EW-1 -: 13];
    assign h2f_vram_wrdata  = head[71:8];
    assign h2f_vram_byteena = head[7:0];
    assign fifo_count       = count_q;
    assign wr_done_count    = done_q;

endmodule

// File: tb/tb_h2f_vram_writer.sv
module tb_h2f_vram_writer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic [12:0] avs_address;
    logic        avs_write;
    logic [63:0] avs_writedata;
    logic [7:0]  avs_byteenable;
    logic        avs_waitrequest;
    logic        vram_wr_grant;
    logic [12:0] h2f_vram_wraddr;
    logic        h2f_vram_wren;
    logic [63:0] h2f_vram_wrdata;
    logic [7:0]  h2f_vram_byteena;
    logic [2:0]  fifo_count;
    logic [15:0] wr_done_count;

    int checks;
    int failures;

    h2f_vram_writer #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .avs_address      (avs_address),
        .avs_write        (avs_write),
        .avs_writedata    (avs_writedata),
        .avs_byteenable   (avs_byteenable),
        .avs_waitrequest  (avs_waitrequest),
        .vram_wr_grant    (vram_wr_grant),
        .h2f_vram_wraddr  (h2f_vram_wraddr),
        .h2f_vram_wren    (h2f_vram_wren),
        .h2f_vram_wrdata  (h2f_vram_wrdata),
        .h2f_vram_byteena (h2f_vram_byteena),
        .fifo_count       (fifo_count),
        .wr_done_count    (wr_done_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic [12:0] a, input logic [63:0] d, input logic [7:0] be);
        avs_write      = 1'b1;
        avs_address    = a;
        avs_writedata  = d;
        avs_byteenable = be;
    endtask

    task automatic idle();
        avs_write      = 1'b0;
        avs_address    = '0;
        avs_writedata  = '0;
        avs_byteenable = '0;
    endtask

    initial begin
        logic [31:0] gpat;
        int          sent;
        int          rcvd;
        logic        will_push;
        logic        will_pop;

        checks   = 0;
        failures = 0;
        gpat     = 32'b1011_0010_0111_0100_1101_1001_0110_1011;

        // Reset with a bus write presented: must be ignored.
        reset         = 1'b1;
        vram_wr_grant = 1'b1;
        set_wr(13'h0123, 64'hDEAD_BEEF_0000_0001, 8'hFF);
        #1;
        chk("rst_wren",  64'(h2f_vram_wren),   64'd0);
        chk("rst_count", 64'(fifo_count),      64'd0);
        chk("rst_wait",  64'(avs_waitrequest), 64'd0);
        chk("rst_addr",  64'(h2f_vram_wraddr), 64'd0);
        chk("rst_data",  h2f_vram_wrdata,      64'd0);
        chk("rst_be",    64'(h2f_vram_byteena),64'd0);
        chk("rst_done",  64'(wr_done_count),   64'd0);
        tick();
        tick();
        chk("rst_wr_ignored_count", 64'(fifo_count),    64'd0);
        chk("rst_wr_ignored_wren",  64'(h2f_vram_wren), 64'd0);

        // Single write through, grant held high; first edge after release.
        reset = 1'b0;
        set_wr(13'h0800, 64'h0123_4567_89AB_CDEF, 8'hFF);
        tick();
        idle();
        chk("single_wren",  64'(h2f_vram_wren),    64'd1);
        chk("single_addr",  64'(h2f_vram_wraddr),  64'h0800);
        chk("single_data",  h2f_vram_wrdata,       64'h0123_4567_89AB_CDEF);
        chk("single_be",    64'(h2f_vram_byteena), 64'hFF);
        chk("single_cnt1",  64'(fifo_count),       64'd1);
        tick();
        chk("single_wren_off", 64'(h2f_vram_wren),   64'd0);
        chk("single_cnt0",     64'(fifo_count),      64'd0);
        chk("single_done",     64'(wr_done_count),   64'd1);
        chk("single_addr_idle",64'(h2f_vram_wraddr), 64'd0);
        chk("single_data_idle",h2f_vram_wrdata,      64'd0);
        tick();
        chk("single_one_cycle", 64'(h2f_vram_wren), 64'd0);

        // Fill to full with grant low.
        vram_wr_grant = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_wr(13'(32'h10 + i), 64'h1111_0000_0000_0000 + 64'(i), 8'hFF);
            tick();
        end
        chk("full_count", 64'(fifo_count),      64'd4);
        chk("full_wait",  64'(avs_waitrequest), 64'd1);
        chk("full_head",  64'(h2f_vram_wraddr), 64'h10);
        set_wr(13'h14, 64'h1111_0000_0000_0004, 8'hFF);
        tick();
        chk("stall_count", 64'(fifo_count),      64'd4);
        chk("stall_wait",  64'(avs_waitrequest), 64'd1);
        chk("stall_head",  64'(h2f_vram_wraddr), 64'h10);
        chk("stall_data",  h2f_vram_wrdata,      64'h1111_0000_0000_0000);
        vram_wr_grant = 1'b1;
        tick();
        vram_wr_grant = 1'b0;
        chk("unstall_wait",  64'(avs_waitrequest), 64'd0);
        chk("unstall_count", 64'(fifo_count),      64'd3);
        chk("unstall_head",  64'(h2f_vram_wraddr), 64'h11);
        tick();
        idle();
        chk("fifth_count", 64'(fifo_count),      64'd4);
        chk("fifth_wait",  64'(avs_waitrequest), 64'd1);
        vram_wr_grant = 1'b1;
        for (int i = 1; i < 5; i++) begin
            chk("drain_addr", 64'(h2f_vram_wraddr), 64'(32'h10 + i));
            chk("drain_data", h2f_vram_wrdata, 64'h1111_0000_0000_0000 + 64'(i));
            tick();
        end
        chk("drain_count", 64'(fifo_count),    64'd0);
        chk("drain_done",  64'(wr_done_count), 64'd6);

        // Ordering and pointer wrap with a toggling grant.
        sent = 0;
        rcvd = 0;
        for (int cyc = 0; cyc < 60 && rcvd < 10; cyc++) begin
            if (sent < 10) set_wr(13'(sent), 64'hA5A5_0000_0000_0000 + 64'(sent), 8'hFF);
            else idle();
            vram_wr_grant = gpat[cyc % 32];
            will_push = avs_write && !avs_waitrequest;
            will_pop  = h2f_vram_wren && vram_wr_grant;
            if (will_pop) begin
                chk("order_addr", 64'(h2f_vram_wraddr), 64'(rcvd));
                chk("order_data", h2f_vram_wrdata, 64'hA5A5_0000_0000_0000 + 64'(rcvd));
                rcvd++;
            end
            if (will_push) sent++;
            tick();
        end
        idle();
        chk("order_rcvd",  64'(rcvd),          64'd10);
        chk("order_count", 64'(fifo_count),    64'd0);
        chk("order_done",  64'(wr_done_count), 64'd16);

        // Zero byte-enable write is dropped.
        vram_wr_grant = 1'b1;
        set_wr(13'h0055, 64'h5555_5555_5555_5555, 8'h00);
        tick();
        idle();
        chk("zbe_wren",  64'(h2f_vram_wren), 64'd0);
        chk("zbe_count", 64'(fifo_count),    64'd0);
        tick();
        chk("zbe_wren2", 64'(h2f_vram_wren), 64'd0);
        set_wr(13'h0056, 64'h6666_6666_6666_6666, 8'h0F);
        tick();
        idle();
        chk("be0f_wren", 64'(h2f_vram_wren),    64'd1);
        chk("be0f_be",   64'(h2f_vram_byteena), 64'h0F);
        chk("be0f_addr", 64'(h2f_vram_wraddr),  64'h56);
        tick();
        chk("be0f_done", 64'(wr_done_count), 64'd17);

        // Simultaneous push and pop at count 2.
        vram_wr_grant = 1'b0;
        set_wr(13'h20, 64'h2020, 8'hFF);
        tick();
        set_wr(13'h21, 64'h2121, 8'hFF);
        tick();
        chk("pp_pre_count", 64'(fifo_count), 64'd2);
        set_wr(13'h22, 64'h2222, 8'hFF);
        vram_wr_grant = 1'b1;
        tick();
        idle();
        chk("pp_count", 64'(fifo_count),      64'd2);
        chk("pp_head1", 64'(h2f_vram_wraddr), 64'h21);
        tick();
        chk("pp_head2", 64'(h2f_vram_wraddr), 64'h22);
        chk("pp_data2", h2f_vram_wrdata,      64'h2222);
        tick();
        chk("pp_empty", 64'(fifo_count),    64'd0);
        chk("pp_done",  64'(wr_done_count), 64'd20);

        // Asynchronous reset pulse between edges with entries pending.
        vram_wr_grant = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_wr(13'(32'h30 + i), 64'h3030 + 64'(i), 8'hFF);
            tick();
        end
        idle();
        chk("mid_count", 64'(fifo_count), 64'd3);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_wren",  64'(h2f_vram_wren),   64'd0);
        chk("arst_count", 64'(fifo_count),      64'd0);
        chk("arst_addr",  64'(h2f_vram_wraddr), 64'd0);
        chk("arst_done",  64'(wr_done_count),   64'd0);
        #1;
        reset = 1'b0;
        vram_wr_grant = 1'b1;
        tick();
        chk("post_rst_wren1", 64'(h2f_vram_wren), 64'd0);
        tick();
        chk("post_rst_wren2", 64'(h2f_vram_wren), 64'd0);
        chk("post_rst_done",  64'(wr_done_count), 64'd0);

        // Stream writes to bring the retire counter to 16'hFFFF, then wrap.
        set_wr(13'h0777, 64'h7777, 8'hFF);
        tick();
        for (int i = 0; i < 65535; i++) tick();
        chk("preload_done",  64'(wr_done_count), 64'hFFFF);
        chk("preload_count", 64'(fifo_count),    64'd1);
        idle();
        tick();
        chk("wrap_done",  64'(wr_done_count), 64'd0);
        chk("wrap_count", 64'(fifo_count),    64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
